// File: rtl/monitor_mode_mapper.sv
// Monitor-emulation colour mapper: colour / green / amber / white modes with
// weighted luma, keyboard mode cycling and frame-aligned mode switching.
module monitor_mode_mapper #(
  parameter int unsigned CW        = 3,
  parameter int unsigned MODE_INIT = 0
) (
  input  logic          clk,
  input  logic          pown_reset_n,
  input  logic [CW-1:0] ri,
  input  logic [CW-1:0] gi,
  input  logic [CW-1:0] bi,
  input  logic          hsync_n,
  input  logic          vsync_n,
  input  logic          mono_force,
  input  logic          mode_cycle,
  output logic [CW-1:0] ro,
  output logic [CW-1:0] go,
  output logic [CW-1:0] bo,
  output logic          hsync_n_o,
  output logic          vsync_n_o,
  output logic [1:0]    mode
);

  localparam int unsigned LW = CW + 3;

  typedef enum logic [1:0] {
    MODE_COLOUR = 2'd0,
    MODE_GREEN  = 2'd1,
    MODE_AMBER  = 2'd2,
    MODE_WHITE  = 2'd3
  } mode_e;

  localparam logic [1:0] MODE_RST = 2'(MODE_INIT);

  // Stage 1 registers
  logic [CW-1:0] r1_q, g1_q, b1_q, l1_q;
  logic          mf1_q, hs1_q, vs1_q;

  // Mode control registers
  logic          cyc_q, armed_q;
  logic [1:0]    pend_q, pend_d;
  logic [1:0]    mode_q, mode_d;

  // Stage 2 registers
  logic [CW-1:0] ro_q, go_q, bo_q;
  logic [CW-1:0] ro_d, go_d, bo_d;
  logic          hs2_q, vs2_q;

  logic [LW-1:0] luma_wide;
  logic [CW-1:0] luma;
  logic          rise, fall;
  mode_e         eff_mode;

  // Weighted luma 2R + 5G + B; the sum fits LW bits and >>3 fits CW bits.
  always_comb begin
    luma_wide = (LW'(ri) << 1) + (LW'(gi) << 2) + LW'(gi) + LW'(bi);
    luma      = luma_wide[LW-1:3];
  end

  // armed_q masks the first cycle after reset so a key held through reset
  // release is not seen as an edge. vs1_q doubles as the vsync fall history.
  always_comb begin
    rise   = mode_cycle & ~cyc_q & armed_q;
    fall   = vs1_q & ~vsync_n;
    pend_d = pend_q + {1'b0, rise};
    mode_d = mode_q;
    if (fall) begin
      mode_d = pend_d;
    end
  end

  always_ff @(posedge clk or negedge pown_reset_n) begin
    if (!pown_reset_n) begin
      r1_q    <= '0;
      g1_q    <= '0;
      b1_q    <= '0;
      l1_q    <= '0;
      mf1_q   <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      cyc_q   <= 1'b0;
      armed_q <= 1'b0;
      pend_q  <= MODE_RST;
      mode_q  <= MODE_RST;
    end else begin
      r1_q    <= ri;
      g1_q    <= gi;
      b1_q    <= bi;
      l1_q    <= luma;
      mf1_q   <= mono_force;
      hs1_q   <= hsync_n;
      vs1_q   <= vsync_n;
      cyc_q   <= mode_cycle;
      armed_q <= 1'b1;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
    end
  end

  // Stage 2 mapping uses the mode active before this edge's update.
  always_comb begin
    ro_d     = r1_q;
    go_d     = g1_q;
    bo_d     = b1_q;
    eff_mode = mode_e'(mode_q);
    if ((mode_q == 2'd0) && mf1_q) begin
      eff_mode = MODE_GREEN;
    end
    unique case (eff_mode)
      MODE_COLOUR: begin
        ro_d = r1_q;
        go_d = g1_q;
        bo_d = b1_q;
      end
      MODE_GREEN: begin
        ro_d = l1_q >> 2;
        go_d = l1_q;
        bo_d = l1_q >> 3;
      end
      MODE_AMBER: begin
        ro_d = l1_q;
        go_d = l1_q - (l1_q >> 2);
        bo_d = '0;
      end
      MODE_WHITE: begin
        ro_d = l1_q;
        go_d = l1_q;
        bo_d = l1_q;
      end
      default: begin
        ro_d = r1_q;
        go_d = g1_q;
        bo_d = b1_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge pown_reset_n) begin
    if (!pown_reset_n) begin
      ro_q  <= '0;
      go_q  <= '0;
      bo_q  <= '0;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
    end else begin
      ro_q  <= ro_d;
      go_q  <= go_d;
      bo_q  <= bo_d;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
    end
  end

  assign ro        = ro_q;
  assign go        = go_q;
  assign bo        = bo_q;
  assign hsync_n_o = hs2_q;
  assign vsync_n_o = vs2_q;
  assign mode      = mode_q;

endmodule

// File: tb/tb_monitor_mode_mapper.sv
// Directed bench for monitor_mode_mapper (CW = 3, MODE_INIT = 0).
module tb_monitor_mode_mapper;

  logic       clk = 1'b0;
  logic       pown_reset_n;
  logic [2:0] ri, gi, bi;
  logic       hsync_n, vsync_n, mono_force, mode_cycle;
  logic [2:0] ro, go, bo;
  logic       hsync_n_o, vsync_n_o;
  logic [1:0] mode;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  monitor_mode_mapper #(.CW(3), .MODE_INIT(0)) dut (
    .clk          (clk),
    .pown_reset_n (pown_reset_n),
    .ri           (ri),
    .gi           (gi),
    .bi           (bi),
    .hsync_n      (hsync_n),
    .vsync_n      (vsync_n),
    .mono_force   (mono_force),
    .mode_cycle   (mode_cycle),
    .ro           (ro),
    .go           (go),
    .bo           (bo),
    .hsync_n_o    (hsync_n_o),
    .vsync_n_o    (vsync_n_o),
    .mode         (mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input logic [2:0] r, input logic [2:0] g, input logic [2:0] b);
    ri = r; gi = g; bi = b;
    tick();
    tick();
  endtask

  task automatic check_rgb(input string tag, input int unsigned r, input int unsigned g,
                           input int unsigned b);
    check({tag, ".r"}, 32'(ro), r);
    check({tag, ".g"}, 32'(go), g);
    check({tag, ".b"}, 32'(bo), b);
  endtask

  task automatic pulse_cycle(input int n);
    for (int i = 0; i < n; i++) begin
      mode_cycle = 1'b1;
      tick();
      mode_cycle = 1'b0;
      tick();
    end
  endtask

  task automatic vs_fall();
    vsync_n = 1'b0;
    tick();
    vsync_n = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    pown_reset_n = 1'b0;
    tick();
    pown_reset_n = 1'b1;
    tick();
  endtask

  initial begin
    pown_reset_n = 1'b0;
    ri = 3'd0; gi = 3'd0; bi = 3'd0;
    hsync_n = 1'b1; vsync_n = 1'b1; mono_force = 1'b0; mode_cycle = 1'b0;

    // Reset state and passthrough
    #23;
    check_rgb("rst", 0, 0, 0);
    check("rst.hs", 32'(hsync_n_o), 1);
    check("rst.vs", 32'(vsync_n_o), 1);
    check("rst.mode", 32'(mode), 0);
    tick();
    pown_reset_n = 1'b1;
    pix(3'd5, 3'd3, 3'd6);
    check_rgb("pass", 5, 3, 6);

    // Mono force gives green in mode 0
    mono_force = 1'b1;
    pix(3'd7, 3'd7, 3'd7);
    check_rgb("green777", 1, 7, 0);
    pix(3'd4, 3'd2, 3'd6);
    check_rgb("green426", 0, 3, 0);
    mono_force = 1'b0;
    pix(3'd4, 3'd2, 3'd6);
    check_rgb("unforce", 4, 2, 6);

    // Mode change only at vsync fall
    pulse_cycle(1);
    repeat (4) tick();
    check("gate.hold", 32'(mode), 0);
    vsync_n = 1'b0;
    tick();
    check("gate.fall", 32'(mode), 1);
    tick();
    check("gate.lowhold", 32'(mode), 1);
    vsync_n = 1'b1;
    tick();
    pulse_cycle(1);
    vs_fall();
    check("amber.mode", 32'(mode), 2);
    pix(3'd7, 3'd7, 3'd7);
    check_rgb("amber777", 7, 6, 0);

    // Wrap-around of pending mode
    do_reset();
    pulse_cycle(5);
    check("wrap.hold", 32'(mode), 0);
    vs_fall();
    check("wrap5", 32'(mode), 1);
    pulse_cycle(3);
    vs_fall();
    check("wrap3", 32'(mode), 0);
    pulse_cycle(3);
    vs_fall();
    check("white.mode", 32'(mode), 3);
    pix(3'd4, 3'd2, 3'd6);
    check_rgb("white426", 3, 3, 3);

    // Rise and fall in the same cycle
    pulse_cycle(3);
    vs_fall();
    check("sim.pre", 32'(mode), 2);
    mode_cycle = 1'b1;
    vsync_n = 1'b0;
    tick();
    check("sim.both", 32'(mode), 3);
    mode_cycle = 1'b0;
    vsync_n = 1'b1;
    tick();

    // Key held across reset release produces no advance
    mode_cycle = 1'b1;
    pown_reset_n = 1'b0;
    tick();
    pown_reset_n = 1'b1;
    repeat (3) tick();
    vs_fall();
    check("held.mode", 32'(mode), 0);
    mode_cycle = 1'b0;
    tick();

    // Sync latency
    hsync_n = 1'b0;
    tick();
    check("hs.lat1", 32'(hsync_n_o), 1);
    hsync_n = 1'b1;
    tick();
    check("hs.lat2", 32'(hsync_n_o), 0);
    tick();
    check("hs.lat3", 32'(hsync_n_o), 1);

    // Asynchronous reset mid-line discards pending mode
    pulse_cycle(3);
    vs_fall();
    check("mid.mode3", 32'(mode), 3);
    pulse_cycle(2);
    check("mid.pendhold", 32'(mode), 3);
    hsync_n = 1'b0;
    pix(3'd7, 3'd7, 3'd7);
    check_rgb("mid.pre", 7, 7, 7);
    check("mid.pre.hs", 32'(hsync_n_o), 0);
    #2;
    pown_reset_n = 1'b0;
    #1;
    check_rgb("mid.rst", 0, 0, 0);
    check("mid.rst.hs", 32'(hsync_n_o), 1);
    check("mid.rst.vs", 32'(vsync_n_o), 1);
    check("mid.rst.mode", 32'(mode), 0);
    hsync_n = 1'b1;
    tick();
    pown_reset_n = 1'b1;
    tick();
    vs_fall();
    check("mid.discard", 32'(mode), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
